// File: rtl/onehot_rr_arbiter.sv
// Four-requester round-robin arbiter with registered one-hot grant,
// owner-controlled release and a hold-time limit that forces release.
module onehot_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic       preempt
);

  localparam int unsigned HW = $clog2(HOLD_MAX + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      ptr, ptr_nx;
  logic [1:0]      own, own_nx;
  logic [HW-1:0]   hcnt, hcnt_nx;
  logic [3:0]      gnt_nx;
  logic            gnt_valid_nx;
  logic            preempt_nx;
  logic [1:0]      win;
  logic            owner_req;
  logic            timeout;
  logic            release_req;

  assign owner_req   = req[own];
  assign timeout     = (hcnt == HW'(HOLD_MAX));
  assign release_req = done | ~owner_req | timeout;

  // First requester at or after ptr; descending scan lets the nearest one win.
  always_comb begin
    win = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) win = ptr + 2'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      own       <= 2'd0;
      hcnt      <= '0;
      gnt       <= 4'b0000;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      own       <= own_nx;
      hcnt      <= hcnt_nx;
      gnt       <= gnt_nx;
      gnt_valid <= gnt_valid_nx;
      preempt   <= preempt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    own_nx       = own;
    hcnt_nx      = hcnt;
    gnt_nx       = gnt;
    gnt_valid_nx = gnt_valid;
    preempt_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          state_nx     = GRANT;
          own_nx       = win;
          gnt_nx       = 4'b0001 << win;
          gnt_valid_nx = 1'b1;
          hcnt_nx      = HW'(1);
        end
      end
      GRANT: begin
        if (release_req) begin
          state_nx     = IDLE;
          gnt_nx       = 4'b0000;
          gnt_valid_nx = 1'b0;
          ptr_nx       = own + 2'd1;
          hcnt_nx      = '0;
          // Only a pure timeout counts as preemption.
          preempt_nx   = timeout & ~done & owner_req;
        end else begin
          hcnt_nx = hcnt + HW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Bench for onehot_rr_arbiter: per-cycle comparison against a behavioural
// model, plus directed scenarios with literal expected grants.
module tb_onehot_rr_arbiter;

  localparam int unsigned HOLD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       preempt;

  int vectors     = 0;
  int miscompares = 0;

  onehot_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  // Model: owner index (-1 when nobody holds), rotating start, cycles held.
  int m_own = -1;
  int m_ptr = 0;
  int m_cnt = 0;
  bit m_pre = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own = -1; m_ptr = 0; m_cnt = 0; m_pre = 1'b0;
    end else begin
      m_pre = 1'b0;
      if (m_own < 0) begin
        bit found;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!found && req[(m_ptr + k) % 4]) begin
            found = 1'b1;
            m_own = (m_ptr + k) % 4;
            m_cnt = 1;
          end
        end
      end else begin
        bit tmo, still;
        tmo   = (m_cnt == int'(HOLD));
        still = req[m_own];
        if (done || !still || tmo) begin
          m_pre = tmo && !done && still;
          m_ptr = (m_own + 1) % 4;
          m_own = -1;
          m_cnt = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
  end

  function automatic logic [3:0] model_gnt();
    return (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model gnt",       gnt,           model_gnt());
      chk("model gnt_valid", 4'(gnt_valid), 4'(m_own >= 0));
      chk("model preempt",   4'(preempt),   4'(m_pre));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    #12;
    chk("reset gnt",       gnt,           4'b0000);
    chk("reset gnt_valid", 4'(gnt_valid), 4'b0000);
    chk("reset preempt",   4'(preempt),   4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // Rotation with done on the first cycle of each grant.
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rotation grant", gnt, 4'(1 << k));
      done = 1'b1;
      step();
      chk("rotation gap", gnt, 4'b0000);
      done = 1'b0;
    end
    step();
    chk("rotation wrap", gnt, 4'b0001);
    done = 1'b1; req = 4'b0000;
    step();
    done = 1'b0;

    // Single request held, then dropped.
    req = 4'b0100;
    step();
    chk("single grant", gnt, 4'b0100);
    chk("single valid", 4'(gnt_valid), 4'b0001);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("single hold", gnt, 4'b0100);
    end
    req = 4'b0000;
    step();
    chk("single drop", gnt, 4'b0000);
    chk("single no preempt", 4'(preempt), 4'b0000);

    // Pointer wrap: owner 3 releases, then 1001 goes to 0 and next to 3.
    req = 4'b1000;
    step();
    chk("wrap owner3", gnt, 4'b1000);
    done = 1'b1; req = 4'b1001;
    step();
    done = 1'b0;
    step();
    chk("wrap to 0", gnt, 4'b0001);
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    chk("wrap then 3", gnt, 4'b1000);
    done = 1'b1; req = 4'b0000;
    step();
    done = 1'b0;

    // Timeout: 8 cycles of 0001, preempt gap, then 0010.
    req = 4'b0011;
    for (int k = 0; k < int'(HOLD); k++) begin
      step();
      chk("timeout hold", gnt, 4'b0001);
      chk("timeout hold preempt", 4'(preempt), 4'b0000);
    end
    step();
    chk("timeout gap", gnt, 4'b0000);
    chk("timeout preempt", 4'(preempt), 4'b0001);
    step();
    chk("timeout next", gnt, 4'b0010);
    chk("timeout next preempt", 4'(preempt), 4'b0000);

    // done on the cycle the hold counter reaches the limit.
    for (int k = 1; k < int'(HOLD); k++) step();
    chk("simul still held", gnt, 4'b0010);
    done = 1'b1;
    step();
    chk("simul gap", gnt, 4'b0000);
    chk("simul preempt", 4'(preempt), 4'b0000);
    done = 1'b0; req = 4'b0000;
    step();

    // Asynchronous reset in the middle of a grant.
    req = 4'b0100;
    begin
      int n;
      n = 0;
      while (gnt !== 4'b0100 && n < 10) begin
        step();
        n++;
      end
      chk("reset-mid grant seen", gnt, 4'b0100);
    end
    #2 rst = 1'b1;
    #1;
    chk("async reset gnt",     gnt,           4'b0000);
    chk("async reset valid",   4'(gnt_valid), 4'b0000);
    chk("async reset preempt", 4'(preempt),   4'b0000);
    @(negedge clk);
    rst = 1'b0; req = 4'b1111;
    step();
    chk("post-reset first", gnt, 4'b0001);
    req = 4'b0000;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
